ddr_note_sched: RTL and testbench



---
 rtl/ddr_note_sched.sv | 248 ++++++++++++++++++++++++
 tb/tb_ddr_note_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_note_sched.sv
// ddr_note_sched -- rhythm-game note scheduler.
// Requests beat patterns, spawns notes into per-lane slots, scrolls them
// down once per frame and judges button presses against a hit window.
// Game flow: IDLE -> PLAY -> DRAIN -> DONE, restartable from IDLE or DONE.
// Optional build macro: DDR_SCHED_PERFECT_EN -- hits close to the target
// line score 2 instead of 1.
module ddr_note_sched #(
   parameter int LANES       = 4,
   parameter int SLOTS       = 4,
   parameter int CORDW       = 10,
   parameter int SPEED       = 4,
   parameter int HIT_Y       = 400,
   parameter int WIN         = 16,
   parameter int BEAT_FRAMES = 8
) (
   input  logic                           clk_pix_i,
   input  logic                           rst_pix_n_i,
   input  logic                           frame_i,
   input  logic                           start_i,
   input  logic [LANES-1:0]               btn_i,
   output logic                           pattern_req_o,
   input  logic                           pattern_valid_i,
   input  logic [LANES-1:0]               pattern_lanes_i,
   input  logic                           pattern_last_i,
   output logic [LANES*SLOTS-1:0]         note_vld_o,
   output logic [LANES*SLOTS*CORDW-1:0]   note_y_o,
   output logic [15:0]                    score_o,
   output logic [7:0]                     combo_o,
   output logic [7:0]                     miss_o,
   output logic [1:0]                     state_o,
   output logic                           overflow_o
);

   localparam int NS        = LANES * SLOTS;
   localparam int BW        = (BEAT_FRAMES > 1) ? $clog2(BEAT_FRAMES) : 1;
   localparam logic [BW-1:0]    BEAT_LAST = BW'(BEAT_FRAMES - 1);
   localparam logic [CORDW:0]   SPEED_W   = SPEED[CORDW:0];
   localparam int MISS_Y    = HIT_Y + WIN;

`ifdef DDR_SCHED_PERFECT_EN
   localparam bit PERFECT = 1'b1;
`else
   localparam bit PERFECT = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   logic [BW-1:0]     r_beat;
   logic              r_req;
   logic [LANES-1:0]  r_btn;
   logic [NS-1:0]     r_vld;
   logic [CORDW-1:0]  r_y [NS];
   logic [15:0]       r_score;
   logic [7:0]        r_combo;
   logic [7:0]        r_miss;
   logic              r_ovf;

   logic              w_active;
   logic              w_transfer;
   logic [LANES-1:0]  w_edge;
   logic [NS-1:0]     w_vld_nxt;
   logic [CORDW-1:0]  w_y_nxt [NS];
   logic [LANES-1:0]  w_found;
   logic [LANES-1:0]  w_free;
   logic [CORDW:0]    w_y_sum;
   logic [CORDW-1:0]  w_y_sat;
   logic              w_bad_press;
   logic              w_drop;
   int                w_hit_cnt;
   int                w_hit_pts;
   int                w_miss_cnt;
   int                w_score_sum;
   int                w_combo_sum;
   int                w_miss_sum;
   logic [15:0]       w_score_new;
   logic [7:0]        w_combo_new;
   logic [7:0]        w_miss_new;

   // True when y lies within +/-half of the target line.
   function automatic logic in_win(input logic [CORDW-1:0] y, input int half);
      int yi;
      yi = int'(y);
      return (yi >= HIT_Y - half) && (yi <= HIT_Y + half);
   endfunction

   assign w_active   = (r_state == ST_PLAY) || (r_state == ST_DRAIN);
   assign w_transfer = (r_state == ST_PLAY) && r_req && pattern_valid_i;
   assign w_edge     = btn_i & ~r_btn;

   // Next slot contents: judge presses on old positions, then scroll, then spawn.
   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_vld_nxt   = r_vld;
      w_y_nxt     = r_y;
      w_found     = '0;
      w_free      = '0;
      w_y_sum     = '0;
      w_y_sat     = '0;
      w_bad_press = 1'b0;
      w_drop      = 1'b0;
      w_hit_cnt   = 0;
      w_hit_pts   = 0;
      w_miss_cnt  = 0;

      // Hit judging: lowest eligible slot per pressed lane.
      for (int l = 0; l < LANES; l++) begin
         if (w_active && w_edge[l]) begin
            for (int s = 0; s < SLOTS; s++) begin
               if (!w_found[l] && r_vld[l*SLOTS+s] && in_win(r_y[l*SLOTS+s], WIN)) begin
                  w_found[l]             = 1'b1;
                  w_vld_nxt[l*SLOTS+s]   = 1'b0;
                  w_hit_cnt              = w_hit_cnt + 1;
                  w_hit_pts = w_hit_pts +
                     ((PERFECT && in_win(r_y[l*SLOTS+s], WIN/2)) ? 2 : 1);
               end
            end
            if (!w_found[l]) w_bad_press = 1'b1;
         end
      end

      // Scroll survivors; anything past the window is a miss.
      if (w_active && frame_i) begin
         for (int i = 0; i < NS; i++) begin
            if (w_vld_nxt[i]) begin
               w_y_sum = {1'b0, r_y[i]} + SPEED_W;
               w_y_sat = w_y_sum[CORDW] ? '1 : w_y_sum[CORDW-1:0];
               if (int'(w_y_sat) > MISS_Y) begin
                  w_vld_nxt[i] = 1'b0;
                  w_miss_cnt   = w_miss_cnt + 1;
               end else begin
                  w_y_nxt[i] = w_y_sat;
               end
            end
         end
      end

      // Spawn into the lowest slot that was free before this cycle.
      if (w_transfer) begin
         for (int l = 0; l < LANES; l++) begin
            if (pattern_lanes_i[l]) begin
               for (int s = 0; s < SLOTS; s++) begin
                  if (!w_free[l] && !r_vld[l*SLOTS+s]) begin
                     w_free[l]            = 1'b1;
                     w_vld_nxt[l*SLOTS+s] = 1'b1;
                     w_y_nxt[l*SLOTS+s]   = '0;
                  end
               end
               if (!w_free[l]) w_drop = 1'b1;
            end
         end
      end
   end

   // Saturating score, combo and miss counters for this cycle.
   always_comb begin
      w_score_sum = int'(r_score) + w_hit_pts;
      w_combo_sum = int'(r_combo) + w_hit_cnt;
      w_miss_sum  = int'(r_miss) + w_miss_cnt;
      w_score_new = (w_score_sum > 65535) ? 16'hFFFF : 16'(w_score_sum);
      w_miss_new  = (w_miss_sum > 255) ? 8'hFF : 8'(w_miss_sum);
      if (w_miss_cnt > 0 || w_bad_press) begin
         w_combo_new = 8'd0;
      end else begin
         w_combo_new = (w_combo_sum > 255) ? 8'hFF : 8'(w_combo_sum);
      end
   end

   // Game FSM, beat/request timing, slot storage and counters.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: the slot array is small and its reset value is observable on the outputs, so it is reset.
   always_ff @(posedge clk_pix_i or negedge rst_pix_n_i) begin
      if (!rst_pix_n_i) begin
         r_state <= ST_IDLE;
         r_beat  <= '0;
         r_req   <= 1'b0;
         r_btn   <= '0;
         r_vld   <= '0;
         r_y     <= '{default: '0};
         r_score <= '0;
         r_combo <= '0;
         r_miss  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_btn <= btn_i;

         if (w_active) begin
            r_vld   <= w_vld_nxt;
            r_y     <= w_y_nxt;
            r_score <= w_score_new;
            r_combo <= w_combo_new;
            r_miss  <= w_miss_new;
            r_ovf   <= r_ovf | w_drop;
         end

         unique case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  r_state <= ST_PLAY;
                  r_beat  <= '0;
                  r_req   <= 1'b0;
                  r_vld   <= '0;
                  r_y     <= '{default: '0};
                  r_score <= '0;
                  r_combo <= '0;
                  r_miss  <= '0;
                  r_ovf   <= 1'b0;
               end
            end
            ST_PLAY: begin
               if (frame_i) begin
                  r_beat <= (r_beat == BEAT_LAST) ? '0 : r_beat + 1'b1;
               end
               if (w_transfer) begin
                  r_req <= 1'b0;
                  if (pattern_last_i) r_state <= ST_DRAIN;
               end else if (frame_i && r_beat == BEAT_LAST) begin
                  r_req <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (~|r_vld) r_state <= ST_DONE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Flatten slot positions onto the output bus.
   always_comb begin
      note_y_o = '0;
      for (int i = 0; i < NS; i++) note_y_o[i*CORDW +: CORDW] = r_y[i];
   end

   assign note_vld_o    = r_vld;
   assign pattern_req_o = r_req;
   assign score_o       = r_score;
   assign combo_o       = r_combo;
   assign miss_o        = r_miss;
   assign state_o       = r_state;
   assign overflow_o    = r_ovf;

endmodule

// File: tb/tb_ddr_note_sched.sv
// Scoreboard bench for ddr_note_sched with default parameters.
module tb_ddr_note_sched;

   localparam int LANES = 4;
   localparam int SLOTS = 4;
   localparam int CORDW = 10;
   localparam int BEAT  = 8;
`ifdef DDR_SCHED_PERFECT_EN
   localparam int PTS = 2;
`else
   localparam int PTS = 1;
`endif

   logic                         clk = 1'b0;
   logic                         rst_n;
   logic                         frame;
   logic                         start;
   logic [LANES-1:0]             btn;
   logic                         req;
   logic                         pat_valid;
   logic [LANES-1:0]             pat_lanes;
   logic                         pat_last;
   logic [LANES*SLOTS-1:0]       vld;
   logic [LANES*SLOTS*CORDW-1:0] note_y;
   logic [15:0]                  score;
   logic [7:0]                   combo;
   logic [7:0]                   miss;
   logic [1:0]                   state;
   logic                         ovf;

   ddr_note_sched dut (
      .clk_pix_i       (clk),
      .rst_pix_n_i     (rst_n),
      .frame_i         (frame),
      .start_i         (start),
      .btn_i           (btn),
      .pattern_req_o   (req),
      .pattern_valid_i (pat_valid),
      .pattern_lanes_i (pat_lanes),
      .pattern_last_i  (pat_last),
      .note_vld_o      (vld),
      .note_y_o        (note_y),
      .score_o         (score),
      .combo_o         (combo),
      .miss_o          (miss),
      .state_o         (state),
      .overflow_o      (ovf)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int s_exp    = 0;

   typedef struct {
      string tag;
      int    val;
   } exp_t;
   exp_t exp_q[$];

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push_exp(input string tag, input int val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic pop_check(input int got);
      exp_t e;
      if (exp_q.size() == 0) begin
         check("sb_empty", exp_q.size(), 1);
      end else begin
         e = exp_q.pop_front();
         check(e.tag, got, e.val);
      end
   endtask

   function automatic int y_of(input int idx);
      return int'(note_y[idx*CORDW +: CORDW]);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame_pulse();
      frame = 1'b1;
      tick();
      frame = 1'b0;
   endtask

   task automatic press(input logic [LANES-1:0] lanes);
      btn = lanes;
      tick();
      btn = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Advance frames until a request is pending (bounded), then transfer.
   task automatic do_transfer(input logic [LANES-1:0] lanes, input logic last);
      int n;
      n = 0;
      while (!req && n < 2*BEAT) begin
         frame_pulse();
         n++;
      end
      check("req_seen", int'(req), 1);
      pat_valid = 1'b1;
      pat_lanes = lanes;
      pat_last  = last;
      tick();
      pat_valid = 1'b0;
      pat_lanes = '0;
      pat_last  = 1'b0;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0; frame = 1'b0; start = 1'b0; btn = '0;
      pat_valid = 1'b0; pat_lanes = '0; pat_last = 1'b0;
      #12;
      push_exp("rst_state", 0); pop_check(int'(state));
      push_exp("rst_req", 0);   pop_check(int'(req));
      push_exp("rst_vld", 0);   pop_check(int'(vld));
      push_exp("rst_score", 0); pop_check(int'(score));
      push_exp("rst_ovf", 0);   pop_check(int'(ovf));
      rst_n = 1'b1;
      tick();

      // Start and spawn one lane-0 note.
      do_start();
      push_exp("start_state", 1); pop_check(int'(state));
      do_transfer(4'b0001, 1'b0);
      push_exp("spawn_vld", 1); pop_check(int'(vld[0]));
      push_exp("spawn_y", 0);   pop_check(y_of(0));
      push_exp("spawn_req", 0); pop_check(int'(req));
      repeat (100) frame_pulse();
      push_exp("y_400", 400);   pop_check(y_of(0));

      // Hit at the target line.
      press(4'b0001);
      s_exp += PTS;
      push_exp("hit_vld", 0);       pop_check(int'(vld[0]));
      push_exp("hit_combo", 1);     pop_check(int'(combo));
      push_exp("hit_score", s_exp); pop_check(int'(score));
      tick();

      // Miss: last valid position, then cleared on the next frame.
      do_transfer(4'b0001, 1'b0);
      repeat (104) frame_pulse();
      push_exp("edge_vld", 1);   pop_check(int'(vld[0]));
      push_exp("edge_y", 416);   pop_check(y_of(0));
      frame_pulse();
      push_exp("miss_vld", 0);   pop_check(int'(vld[0]));
      push_exp("miss_cnt", 1);   pop_check(int'(miss));
      push_exp("miss_combo", 0); pop_check(int'(combo));

      // Hit at the early window edge in lane 2.
      do_transfer(4'b0100, 1'b0);
      repeat (96) frame_pulse();
      push_exp("l2_y", 384);      pop_check(y_of(2*SLOTS));
      press(4'b0100);
      s_exp += 1;
      push_exp("l2_vld", 0);      pop_check(int'(vld[2*SLOTS]));
      push_exp("l2_combo", 1);    pop_check(int'(combo));
      push_exp("l2_score", s_exp); pop_check(int'(score));
      tick();

      // Press on an empty lane breaks the combo only.
      press(4'b0010);
      push_exp("empty_combo", 0);     pop_check(int'(combo));
      push_exp("empty_score", s_exp); pop_check(int'(score));
      tick();

      // Overflow: five spawns into lane 0.
      do_reset();
      do_start();
      for (int i = 0; i < 5; i++) begin
         do_transfer(4'b0001, 1'b0);
         if (i == 3) begin
            push_exp("full4_vld", 15); pop_check(int'(vld[SLOTS-1:0]));
            push_exp("full4_ovf", 0);  pop_check(int'(ovf));
         end
      end
      push_exp("ovf_vld", 15); pop_check(int'(vld[SLOTS-1:0]));
      push_exp("ovf_flag", 1); pop_check(int'(ovf));

      // Reset mid-play with a pending request and notes in flight.
      n = 0;
      while (!req && n < 2*BEAT) begin
         frame_pulse();
         n++;
      end
      check("pre_rst_req", int'(req), 1);
      rst_n = 1'b0;
      #2;
      push_exp("mid_rst_state", 0); pop_check(int'(state));
      push_exp("mid_rst_vld", 0);   pop_check(int'(vld));
      push_exp("mid_rst_req", 0);   pop_check(int'(req));
      push_exp("mid_rst_ovf", 0);   pop_check(int'(ovf));
      rst_n = 1'b1;
      tick();

      // Last pattern: DRAIN, note misses, DONE, restart.
      do_start();
      do_transfer(4'b0001, 1'b1);
      push_exp("drain_state", 2); pop_check(int'(state));
      repeat (16) frame_pulse();
      push_exp("drain_req", 0);   pop_check(int'(req));
      n = 0;
      while (state != 2'd3 && n < 300) begin
         frame_pulse();
         n++;
      end
      push_exp("done_state", 3); pop_check(int'(state));
      push_exp("done_miss", 1);  pop_check(int'(miss));
      push_exp("done_vld", 0);   pop_check(int'(vld));
      frame_pulse();
      press(4'b0001);
      tick();
      push_exp("done_hold_miss", 1);  pop_check(int'(miss));
      push_exp("done_hold_state", 3); pop_check(int'(state));
      do_start();
      push_exp("restart_state", 1); pop_check(int'(state));
      push_exp("restart_score", 0); pop_check(int'(score));
      push_exp("restart_miss", 0);  pop_check(int'(miss));

      check("sb_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
